mem_tracker: RTL

- Downstream neighbour of the instruction-fetch tracker.
- Consumes load/store records (instruction, address, decode-end time) emitted on `if_data_ready`.
- Observes the core's data-memory port and pairs each req/gnt/rvalid transaction, in order, with the oldest pending load/store.
- Emits one timestamped trace record per completed memory access to the trace buffer, using a valid/ready handshake.

---
 rtl/gouram_trace_pkg.sv | 43 ++++
 rtl/mem_tracker_if.sv | 13 +
 rtl/mem_tracker_trace_fifo.sv | 51 +++++
 rtl/mem_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared types for the memory-access tracker: pending load/store entries, trace records, FSM states.
// Optional MEM_TRACKER_DATA_EN adds a data field to every trace record.
package gouram_trace_pkg;

    localparam int INSTR_ADDR_W = 16;
    localparam int INSTR_DATA_W = 32;
    localparam int DATA_ADDR_W  = 32;
    localparam int DATA_DATA_W  = 32;
    localparam int TIME_W       = 32;

    typedef enum logic [1:0] {
        TRACK_REQ    = 2'd0,
        TRACK_GRANT  = 2'd1,
        TRACK_RVALID = 2'd2
    } track_state_t;

    typedef struct packed {
        logic [INSTR_DATA_W-1:0] instruction;
        logic [INSTR_ADDR_W-1:0] instr_addr;
        logic [TIME_W-1:0]       dec_end;
    } pending_t;

    typedef struct packed {
        logic [INSTR_DATA_W-1:0] instruction;
        logic [INSTR_ADDR_W-1:0] instr_addr;
        logic [DATA_ADDR_W-1:0]  data_addr;
        logic                    is_store;
        logic                    matched;
        logic [TIME_W-1:0]       dec_end;
        logic [TIME_W-1:0]       req_start;
        logic [TIME_W-1:0]       gnt;
        logic [TIME_W-1:0]       rvalid;
`ifdef MEM_TRACKER_DATA_EN
        logic [DATA_DATA_W-1:0]  data;
`endif
    } mem_trace_t;

    // RISC-V STORE major opcode; lets consumers classify a record's instruction word.
    function automatic logic check_store(input logic [INSTR_DATA_W-1:0] instr);
        return instr[6:0] == 7'b0100011;
    endfunction

endpackage

// File: rtl/mem_tracker_if.sv
// Trace-record stream from mem_tracker to the trace buffer.
// Handshake: a record transfers on a clock edge where rec_valid && rec_ready; rec_o holds while rec_valid && !rec_ready.
interface mem_tracker_if;
    import gouram_trace_pkg::*;

    logic       rec_valid;
    logic       rec_ready;
    mem_trace_t rec_o;

    modport master (output rec_valid, output rec_o, input rec_ready);
    modport slave  (input rec_valid, input rec_o, output rec_ready);

endinterface

// File: rtl/mem_tracker_trace_fifo.sv
// Generic typed FIFO with extra-bit pointers; head reads as zero while empty.
// A push to a full FIFO succeeds when a pop happens in the same cycle.
module trace_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;
    T            mem_q [DEPTH];

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        // Pop only sees entries written on earlier edges.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = empty ? T'('0) : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_tracker.sv
// Pairs each data-memory req/gnt/rvalid transaction with the oldest pending load/store and emits trace records.
// Define MEM_TRACKER_DATA_EN to carry load/store data in each record.
module mem_tracker
    import gouram_trace_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH    = INSTR_ADDR_W,
    parameter int INSTR_DATA_WIDTH    = INSTR_DATA_W,
    parameter int DATA_ADDR_WIDTH     = DATA_ADDR_W,
    parameter int DATA_DATA_WIDTH     = DATA_DATA_W,
    parameter int PENDING_BUFFER_SIZE = 8,
    parameter int OUT_BUFFER_SIZE     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 counter,
    input  logic                        if_data_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] if_instruction,
    input  logic [INSTR_ADDR_WIDTH-1:0] if_instr_addr,
    input  logic [31:0]                 dec_stage_end,
    input  logic                        data_req,
    input  logic                        data_gnt,
    input  logic                        data_rvalid,
    input  logic [DATA_ADDR_WIDTH-1:0]  data_addr,
    input  logic                        data_we,
    input  logic [DATA_DATA_WIDTH-1:0]  data_rdata,
    input  logic [DATA_DATA_WIDTH-1:0]  data_wdata,
    mem_tracker_if.master               rec_if,
    output logic                        overflow,
    output logic                        unmatched,
    output track_state_t                dbg_state
);

    track_state_t               state_q, state_d;
    logic [31:0]                req_start_q, req_start_d;
    logic [31:0]                gnt_q, gnt_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       we_q, we_d;
    logic                       overflow_q, overflow_d;
    logic                       unmatched_q, unmatched_d;
`ifdef MEM_TRACKER_DATA_EN
    logic [DATA_DATA_WIDTH-1:0] wdata_q, wdata_d;
`else
    logic                       unused_data;
    assign unused_data = ^{data_rdata, data_wdata};
`endif

    logic       start_req, take_gnt, complete;
    pending_t   pend_in, pend_head;
    logic       pend_full, pend_empty;
    mem_trace_t rec_in, out_head;
    logic       out_full, out_empty, out_pop;

    assign pend_in = '{instruction: if_instruction, instr_addr: if_instr_addr, dec_end: dec_stage_end};

    trace_fifo #(.T(pending_t), .DEPTH(PENDING_BUFFER_SIZE)) u_pend_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (if_data_ready),
        .wdata (pend_in),
        .pop   (complete),
        .rdata (pend_head),
        .full  (pend_full),
        .empty (pend_empty)
    );

    trace_fifo #(.T(mem_trace_t), .DEPTH(OUT_BUFFER_SIZE)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (complete),
        .wdata (rec_in),
        .pop   (out_pop),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    // Tracking FSM: a completing rvalid may chain straight into the next request.
    always_comb begin
        state_d     = state_q;
        req_start_d = req_start_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
`ifdef MEM_TRACKER_DATA_EN
        wdata_d     = wdata_q;
`endif
        start_req   = 1'b0;
        take_gnt    = 1'b0;
        complete    = 1'b0;

        case (state_q)
            TRACK_REQ: begin
                start_req = data_req;
            end
            TRACK_GRANT: begin
                take_gnt = data_gnt;
            end
            TRACK_RVALID: begin
                if (data_rvalid) begin
                    complete  = 1'b1;
                    start_req = data_req;
                    state_d   = TRACK_REQ;
                end
            end
            default: begin
                state_d = TRACK_REQ;
            end
        endcase

        if (start_req) begin
            req_start_d = counter;
            take_gnt    = data_gnt;
            state_d     = TRACK_GRANT;
        end

        if (take_gnt) begin
            gnt_d   = counter;
            addr_d  = data_addr;
            we_d    = data_we;
`ifdef MEM_TRACKER_DATA_EN
            wdata_d = data_wdata;
`endif
            state_d = TRACK_RVALID;
        end
    end

    always_comb begin
        rec_in             = '0;
        rec_in.instruction = pend_empty ? '0 : pend_head.instruction;
        rec_in.instr_addr  = pend_empty ? '0 : pend_head.instr_addr;
        rec_in.dec_end     = pend_empty ? '0 : pend_head.dec_end;
        rec_in.matched     = !pend_empty;
        rec_in.data_addr   = addr_q;
        rec_in.is_store    = we_q;
        rec_in.req_start   = req_start_q;
        rec_in.gnt         = gnt_q;
        rec_in.rvalid      = counter;
`ifdef MEM_TRACKER_DATA_EN
        rec_in.data        = we_q ? wdata_q : data_rdata;
`endif
    end

    always_comb begin
        out_pop     = !out_empty && rec_if.rec_ready;
        overflow_d  = overflow_q
                    | (if_data_ready && pend_full && !complete)
                    | (complete && out_full && !out_pop);
        unmatched_d = unmatched_q | (complete && pend_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TRACK_REQ;
            req_start_q <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            overflow_q  <= 1'b0;
            unmatched_q <= 1'b0;
`ifdef MEM_TRACKER_DATA_EN
            wdata_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_start_q <= req_start_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            overflow_q  <= overflow_d;
            unmatched_q <= unmatched_d;
`ifdef MEM_TRACKER_DATA_EN
            wdata_q     <= wdata_d;
`endif
        end
    end

    assign rec_if.rec_valid = !out_empty;
    assign rec_if.rec_o     = out_head;
    assign overflow         = overflow_q;
    assign unmatched        = unmatched_q;
    assign dbg_state        = state_q;

endmodule
